pipeline_control: RTL and testbench

Central sequencing block for the 4-stage (IF/ID/EX/WB) 8-bit processor. It tracks a valid bit per stage and resolves jumps in ID, driving PC increment/load and squashing the wrong-path fetch. It also generates operand-forwarding selects and the WB register-write enable. A run/halt/single-step FSM gates fetch and drains the pipeline for debug.

---
 rtl/pipeline_control_if.sv | 13 +
 rtl/pipeline_control.sv | 120 ++++++++++++
 tb/tb_pipeline_control.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_if.sv
// Fetch-side bus between the PC/instruction-memory unit (master) and pipeline_control (slave).
interface pipeline_control_if #(
    parameter int unsigned PC_W = 8
);
    logic [7:0]      if_instr;
    logic [PC_W-1:0] if_pc;
    logic            pc_en;
    logic            pc_load;
    logic [PC_W-1:0] pc_target;

    modport master (output if_instr, if_pc, input pc_en, pc_load, pc_target);
    modport slave  (input if_instr, if_pc, output pc_en, pc_load, pc_target);
endinterface

// File: rtl/pipeline_control.sv
// Sequencing for the 4-stage IF/ID/EX/WB pipeline: stage valids, jump redirect in ID,
// operand forwarding selects and a run/drain/halt/step debug FSM.
module pipeline_control #(
    parameter int unsigned PC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_control_if.slave  fetch,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    output logic [7:0]         id_instr,
    output logic               id_valid,
    output logic               ex_valid,
    output logic               wb_valid,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               wb_we,
    output logic               halted,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10,
        STEP   = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] id_pc;
    logic [PC_W-7:0] jump_page;
    logic [2:0]      id_rd, id_rs, ex_rd, wb_rd;
    logic            ex_writes, wb_writes;
    logic            fetch_en, jump_id;

    function automatic logic [1:0] fwd_sel(input logic [2:0] r,
                                           input logic ex_w, input logic [2:0] ex_r,
                                           input logic wb_w, input logic [2:0] wb_r);
        if (ex_w && ex_r == r)      return 2'b01;
        else if (wb_w && wb_r == r) return 2'b10;
        else                        return 2'b00;
    endfunction

    assign fetch_en = (state_q == RUN) || (state_q == STEP);
    assign jump_id  = id_valid & id_instr[7];
    assign id_rd    = id_instr[5:3];
    assign id_rs    = id_instr[2:0];

    // Upper bits of id_pc+1: the page only advances when the low six bits carry out.
    assign jump_page = id_pc[PC_W-1:6] + (PC_W-6)'(&id_pc[5:0]);

    assign fetch.pc_load   = jump_id;
    assign fetch.pc_target = {jump_page, id_instr[5:0]};
    assign fetch.pc_en     = reset & (fetch_en | jump_id);

    assign wb_we  = wb_valid & wb_writes;
    assign halted = (state_q == HALTED);
    assign state  = state_q;

    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        if (id_valid) begin
            fwd_a_sel = fwd_sel(id_rd, ex_writes, ex_rd, wb_writes, wb_rd);
            fwd_b_sel = fwd_sel(id_rs, ex_writes, ex_rd, wb_writes, wb_rd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:    if (halt_req) state_d = DRAIN;
            DRAIN: begin
                if (run_req)                     state_d = RUN;
                else if (!id_valid && !ex_valid) state_d = HALTED;
            end
            HALTED: begin
                if (run_req)       state_d = RUN;
                else if (step_req) state_d = STEP;
            end
            STEP:   state_d = DRAIN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_instr  <= '0;
            id_pc     <= '0;
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_writes <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_writes <= 1'b0;
        end else begin
            if (fetch_en && !jump_id) begin
                id_instr <= fetch.if_instr;
                id_pc    <= fetch.if_pc;
                id_valid <= 1'b1;
            end else begin
                id_valid <= 1'b0;
            end
            ex_valid  <= id_valid;
            ex_rd     <= id_rd;
            ex_writes <= id_valid & ~id_instr[7];
            wb_valid  <= ex_valid;
            wb_rd     <= ex_rd;
            wb_writes <= ex_writes;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: per-cycle vector table for fill/forward/jump,
// then hand-written halt, step, run and asynchronous-reset sequences.
module tb_pipeline_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
    logic [7:0] id_instr;
    logic       id_valid, ex_valid, wb_valid, wb_we, halted;
    logic [1:0] fwd_a_sel, fwd_b_sel, state;

    logic [7:0] imem [256];
    logic [7:0] pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_control_if #(.PC_W(8)) fbus ();

    pipeline_control #(.PC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fbus),
        .run_req   (run_req),
        .halt_req  (halt_req),
        .step_req  (step_req),
        .id_instr  (id_instr),
        .id_valid  (id_valid),
        .ex_valid  (ex_valid),
        .wb_valid  (wb_valid),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .wb_we     (wb_we),
        .halted    (halted),
        .state     (state)
    );

    // Fetch unit model: PC register plus instruction memory.
    always_comb begin
        fbus.if_pc    = pc;
        fbus.if_instr = imem[pc];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)           pc <= 8'h00;
        else if (fbus.pc_en)  pc <= fbus.pc_load ? fbus.pc_target : pc + 8'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       run, halt, step;
        logic [1:0] st;
        logic       pc_en, pc_load;
        logic [7:0] tgt;
        logic [7:0] idi;
        logic       idv, exv, wbv;
        logic [1:0] fa, fb;
        logic       we;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int          we_cnt, pen_cnt;
        logic [7:0]  pc0, jmp_pc, tmp;

        for (int unsigned a = 0; a < 256; a++) imem[a] = 8'h3F;  // MOV r7,r7
        imem[8'h00] = 8'h0A;  // MOV r1,r2
        imem[8'h01] = 8'h49;  // ADD r1,r1
        imem[8'h02] = 8'h59;  // ADD r3,r1
        imem[8'h03] = 8'h2C;  // MOV r5,r4
        imem[8'h04] = 8'h13;  // MOV r2,r3
        imem[8'h05] = 8'hBF;  // JMP 0x3F
        imem[8'h3F] = 8'h36;  // MOV r6,r6
        imem[8'h40] = 8'h95;  // JMP 0x15 -> 0x55
        imem[8'h55] = 8'h25;  // MOV r4,r5

        //             run halt step st     pen ld  tgt    idi    idv exv wbv fa     fb     we
        tbl[0]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h0A,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h49,1'b1,1'b1,1'b0,2'b01,2'b01,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h59,1'b1,1'b1,1'b1,2'b00,2'b01,1'b1};
        tbl[4]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h2C,1'b1,1'b1,1'b1,2'b00,2'b00,1'b1};
        tbl[5]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h13,1'b1,1'b1,1'b1,2'b00,2'b10,1'b1};
        tbl[6]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,8'h3F,8'hBF,1'b1,1'b1,1'b1,2'b00,2'b00,1'b1};
        tbl[7]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'hBF,1'b0,1'b1,1'b1,2'b00,2'b00,1'b1};
        tbl[8]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h36,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,8'h55,8'h95,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h95,1'b0,1'b1,1'b1,2'b00,2'b00,1'b1};
        tbl[11] = '{1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,8'h00,8'h25,1'b1,1'b0,1'b1,2'b00,2'b00,1'b0};

        // Held in reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_en", fbus.pc_en, 1'b0);
        chk("rst_state", state, 2'b00);
        chk("rst_valids", {id_valid, ex_valid, wb_valid}, 3'b000);
        chk("rst_id_instr", id_instr, 8'h00);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_req = tbl[i].run; halt_req = tbl[i].halt; step_req = tbl[i].step;
            #1;
            chk($sformatf("v%0d_state", i), state, tbl[i].st);
            chk($sformatf("v%0d_pc_en", i), fbus.pc_en, tbl[i].pc_en);
            chk($sformatf("v%0d_pc_load", i), fbus.pc_load, tbl[i].pc_load);
            if (tbl[i].pc_load) chk($sformatf("v%0d_target", i), fbus.pc_target, tbl[i].tgt);
            chk($sformatf("v%0d_id_instr", i), id_instr, tbl[i].idi);
            chk($sformatf("v%0d_valids", i), {id_valid, ex_valid, wb_valid},
                {tbl[i].idv, tbl[i].exv, tbl[i].wbv});
            chk($sformatf("v%0d_fwd_a", i), fwd_a_sel, tbl[i].fa);
            chk($sformatf("v%0d_fwd_b", i), fwd_b_sel, tbl[i].fb);
            chk($sformatf("v%0d_wb_we", i), wb_we, tbl[i].we);
            @(negedge clk);
        end
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;

        // Halt with a full pipeline
        @(negedge clk);
        halt_req = 1'b1;
        #1;
        chk("halt_full", {id_valid, ex_valid, wb_valid}, 3'b111);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            halt_req = 1'b0;
            #1;
            chk($sformatf("drain%0d_state", c), state, 2'b01);
            chk($sformatf("drain%0d_pc_en", c), fbus.pc_en, 1'b0);
            if (c == 1) chk("drain1_id_valid", id_valid, 1'b1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            halt_req = (c == 1);
            #1;
            chk($sformatf("halt%0d_halted", c), halted, 1'b1);
            chk($sformatf("halt%0d_state", c), state, 2'b10);
            chk($sformatf("halt%0d_pc_en", c), fbus.pc_en, 1'b0);
        end
        halt_req = 1'b0;
        chk("halt_valids", {id_valid, ex_valid, wb_valid}, 3'b000);

        // Three single steps, 5 cycles apart
        pc0 = pc; we_cnt = 0; pen_cnt = 0;
        for (int s = 0; s < 3; s++) begin
            step_req = 1'b1;
            #1;
            chk($sformatf("step%0d_start", s), state, 2'b10);
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                step_req = 1'b0;
                #1;
                we_cnt  += int'(wb_we);
                pen_cnt += int'(fbus.pc_en);
                if (c == 1) chk($sformatf("step%0d_STEP", s), state, 2'b11);
                if (c == 2) chk($sformatf("step%0d_DRAIN", s), state, 2'b01);
                if (c == 4) chk($sformatf("step%0d_wb_we", s), wb_we, 1'b1);
                if (c == 5) chk($sformatf("step%0d_halted", s), halted, 1'b1);
            end
        end
        chk("step_we_count", we_cnt, 3);
        chk("step_pc_en_count", pen_cnt, 3);
        tmp = pc - pc0;
        chk("step_pc_delta", tmp, 8'd3);

        // step_req and run_req together in HALTED: run wins
        step_req = 1'b1; run_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0; run_req = 1'b0;
        #1;
        chk("both_req_state", state, 2'b00);
        chk("both_req_pc_en", fbus.pc_en, 1'b1);
        @(negedge clk);
        #1;
        chk("run_fetch_id_valid", id_valid, 1'b1);

        // run_req during DRAIN
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0; run_req = 1'b1;
        #1;
        chk("rd_drain_state", state, 2'b01);
        @(negedge clk);
        run_req = 1'b0;
        #1;
        chk("rd_run_state", state, 2'b00);
        chk("rd_run_pc_en", fbus.pc_en, 1'b1);
        chk("rd_bubble", id_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("rd_resumed", id_valid, 1'b1);

        // Reset asserted mid-DRAIN with a JMP in ID
        jmp_pc = pc;
        imem[pc] = 8'h95;
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        tmp = jmp_pc + 8'd1;
        chk("dj_state", state, 2'b01);
        chk("dj_id_instr", id_instr, 8'h95);
        chk("dj_pc_load", fbus.pc_load, 1'b1);
        chk("dj_target", fbus.pc_target, {tmp[7:6], 6'h15});
        #2;
        reset = 1'b0;
        #1;
        chk("ar_pc_en", fbus.pc_en, 1'b0);
        chk("ar_pc_load", fbus.pc_load, 1'b0);
        chk("ar_target", fbus.pc_target, 8'h00);
        chk("ar_id_instr", id_instr, 8'h00);
        chk("ar_valids", {id_valid, ex_valid, wb_valid}, 3'b000);
        chk("ar_fwd", {fwd_a_sel, fwd_b_sel}, 4'b0000);
        chk("ar_wb_we", wb_we, 1'b0);
        chk("ar_halted", halted, 1'b0);
        chk("ar_state", state, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_state", state, 2'b00);
        chk("rel_valids", {id_valid, ex_valid, wb_valid}, 3'b000);
        chk("rel_pc_en", fbus.pc_en, 1'b1);
        @(negedge clk);
        #1;
        chk("rel_first_fetch", {id_valid, id_instr}, {1'b1, 8'h0A});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
